// File: rtl/reg_dump_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_ctrl_if
//  Purpose  : Bundle of the control, register-file read-port and output
//             valid/ready signals used by the register dump engine.
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_dump_ctrl_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
);
  logic             start;
  logic             abort;
  logic [DEPTH-1:0] first_addr;
  logic [DEPTH-1:0] last_addr;
  logic [DEPTH-1:0] rf_addr;
  logic [WIDTH-1:0] rf_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [DEPTH-1:0] out_addr;
  logic             busy;
  logic             done;

  // Dump engine side
  modport master (
    input  start, abort, first_addr, last_addr, rf_data, out_ready,
    output rf_addr, out_valid, out_data, out_addr, busy, done
  );

  // Requester / register file / consumer side
  modport slave (
    output start, abort, first_addr, last_addr, rf_data, out_ready,
    input  rf_addr, out_valid, out_data, out_addr, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_ctrl
//  Purpose  : Sweeps an inclusive, wrapping address range of the register
//             file read port and streams (address, data) pairs downstream
//             over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_dump_ctrl #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  wire              clk,
  input  wire              rst,
  reg_dump_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_PRESENT = 2'd2,
    S_FIN     = 2'd3
  } state_t;

  localparam logic [DEPTH:0] c_one = (DEPTH+1)'(1);

  state_t           r_state;
  logic [DEPTH:0]   r_remaining;
  logic [DEPTH-1:0] r_rf_addr;
  logic [WIDTH-1:0] r_out_data;
  logic [DEPTH-1:0] r_out_addr;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;

  logic [DEPTH-1:0] w_span;
  logic [DEPTH:0]   w_count;
  logic             w_handshake;

  // Word count of the requested range; the subtraction wraps so last<first
  // runs through the top of the file and first==last+1 covers every entry.
  assign w_span      = bus.last_addr - bus.first_addr;
  assign w_count     = {1'b0, w_span} + c_one;
  assign w_handshake = r_out_valid && bus.out_ready;

  // Sweep sequencer with all outputs registered. The range bounds are not
  // kept: the start address lives on in r_rf_addr and the end is implied by
  // r_remaining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_rf_addr   <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rf_addr   <= bus.first_addr;
            r_remaining <= w_count;
            r_busy      <= 1'b1;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            // Snapshot: later register writes cannot disturb this word.
            r_out_data  <= bus.rf_data;
            r_out_addr  <= r_rf_addr;
            r_out_valid <= 1'b1;
            r_state     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (bus.abort) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_handshake) begin
            r_out_valid <= 1'b0;
            if (r_remaining > c_one) begin
              r_remaining <= r_remaining - c_one;
              r_rf_addr   <= r_rf_addr + DEPTH'(1);
              r_state     <= S_READ;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rf_addr   = r_rf_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_addr  = r_out_addr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_dump_ctrl
//  Purpose  : Self-checking bench for reg_dump_ctrl; a behavioural register
//             file plus an expected-word list built from the range rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_ctrl;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int N     = 1 << DEPTH;
  localparam int MAXC  = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [WIDTH-1:0] rf [N];

  reg_dump_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  reg_dump_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural register file: combinational read.
  assign bus.rf_data = rf[bus.rf_addr];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload_linear();
    for (int i = 0; i < N; i++) rf[i] = 32'h100 + i;
  endtask

  // One sweep: builds the expected stream from the range rules, then drives
  // the consumer and compares every presented word and status flag.
  task automatic sweep(input int first, input int last, input int pct,
                       input int hold, input int abort_word, input bit glitch,
                       input bit wr);
    int               exp_addr[$];
    logic [WIDTH-1:0] exp_data[$];
    int  n, words;
    bit  finished, aborted, timed, ready, do_abort, wrote;
    n = ((last - first) % N + N) % N + 1;
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back((first + k) % N);
      exp_data.push_back(rf[(first + k) % N]);
    end
    timed    = (pct == 100) && (hold == 0) && (abort_word == 0);
    words    = 0;
    finished = 0;
    aborted  = 0;
    wrote    = 0;

    bus.first_addr = DEPTH'(first);
    bus.last_addr  = DEPTH'(last);
    bus.start      = 1'b1;
    bus.out_ready  = 1'b0;
    step();
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);

    for (int cyc = 0; cyc < MAXC; cyc++) begin
      if (hold > 0 && cyc <= hold) ready = 0;
      else ready = ($urandom_range(1, 100) <= pct);
      do_abort = (abort_word > 0) && bus.out_valid && (words == abort_word - 1);
      if (do_abort) ready = 1;
      bus.out_ready = ready;
      bus.abort     = do_abort;
      if (glitch && cyc == 2) begin
        bus.start      = 1'b1;
        bus.first_addr = DEPTH'($urandom_range(0, N-1));
        bus.last_addr  = DEPTH'($urandom_range(0, N-1));
      end else begin
        bus.start = 1'b0;
      end

      if (timed) begin
        check("valid_timing", bus.out_valid, (cyc % 2 == 1) && (cyc < 2*n));
        check("done_timing", bus.done, cyc == 2*n);
      end
      check("busy_in_sweep", bus.busy, 1);

      if (bus.out_valid) begin
        if (words < n) begin
          check("out_addr", bus.out_addr, exp_addr[words]);
          check("out_data", bus.out_data, exp_data[words]);
        end else begin
          check("extra_word", words, n - 1);
        end
        if (wr && !wrote && bus.out_addr == 3) begin
          rf[3] = 32'hDEADBEEF;
          wrote = 1;
        end
        if (ready) words++;
      end

      if (bus.done) begin
        check("done_word_count", words, n);
        finished = 1;
      end

      step();

      if (do_abort) begin
        bus.abort = 1'b0;
        check("abort_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_words", words, abort_word);
        aborted = 1;
        break;
      end
      if (finished) begin
        check("post_done_busy", bus.busy, 0);
        check("post_done_pulse", bus.done, 0);
        break;
      end
    end
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    check("sweep_terminated", finished || aborted, 1);
  endtask

  initial begin
    int f, l, nn, ab;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.first_addr = '0;
    bus.last_addr  = '0;
    bus.out_ready  = 1'b0;
    preload_linear();

    // Reset state
    step();
    step();
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rf_addr", bus.rf_addr, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_addr", bus.out_addr, 0);
    rst = 1'b0;
    step();

    // abort in IDLE is ignored
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("idle_abort_busy", bus.busy, 0);

    // Basic range, wrapping range, single word held off by the consumer
    sweep(2, 5, 100, 0, 0, 0, 0);
    sweep(14, 1, 100, 0, 0, 0, 0);
    sweep(7, 7, 100, 6, 0, 0, 0);

    // Abort on the third word, with a start pulse while busy
    sweep(0, 15, 100, 0, 3, 1, 0);

    // Asynchronous reset mid-PRESENT
    bus.first_addr = 4'd2;
    bus.last_addr  = 4'd5;
    bus.start      = 1'b1;
    bus.out_ready  = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    check("pre_rst_valid", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_rf_addr", bus.rf_addr, 0);
    check("arst_out_data", bus.out_data, 0);
    step();
    rst = 1'b0;
    step();
    sweep(0, 1, 100, 0, 0, 0, 0);

    // Register write after capture leaves the presented word untouched
    sweep(2, 4, 40, 2, 0, 0, 1);
    preload_linear();

    // Full wrap range
    sweep(5, 4, 100, 0, 0, 0, 0);

    // Randomized contents, ranges, back-pressure and aborts
    for (int i = 0; i < N; i++) rf[i] = $urandom;
    for (int t = 0; t < 12; t++) begin
      f  = $urandom_range(0, N-1);
      l  = $urandom_range(0, N-1);
      nn = ((l - f) % N + N) % N + 1;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nn) : 0;
      sweep(f, l, $urandom_range(25, 100), 0, ab, $urandom_range(0, 1), 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
